// File: rtl/status_branch_unit.sv
// Latches the ALU {n,z,v} status and resolves one conditional branch at a time
// through an IDLE -> EVAL -> RESP handshake; also counts taken branches.
module status_branch_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flag_we,
    input  logic [2:0]        alu_status,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [DATA_W-1:0] br_pc4,
    input  logic [IMM_W-1:0]  br_imm,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [DATA_W-1:0] res_target,
    output logic [DATA_W-1:0] res_link,
    output logic              res_illegal,
    output logic [2:0]        flags,
    output logic [CNT_W-1:0]  taken_cnt
);

    localparam int unsigned SEXT_W = DATA_W - IMM_W - 2;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_flags;
    logic [2:0]          r_snap;
    logic [2:0]          r_cond;
    logic [DATA_W-1:0]   r_pc4;
    logic [IMM_W-1:0]    r_imm;
    logic                r_valid;
    logic                r_taken;
    logic [DATA_W-1:0]   r_target;
    logic [DATA_W-1:0]   r_link;
    logic                r_illegal;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_accept;
    logic                w_taken;
    logic                w_illegal;
    logic [DATA_W-1:0]   w_offset;
    logic [DATA_W-1:0]   w_target;

    assign w_accept = (r_state == S_IDLE) && br_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (br_valid)  w_next = S_EVAL;
            S_EVAL:                 w_next = S_RESP;
            S_RESP:  if (res_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_flags <= '0;
        else if (flag_we) r_flags <= alu_status;
    end

    // Snapshot bypasses a same-cycle flag write so the branch sees the newest status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap <= '0;
            r_cond <= '0;
            r_pc4  <= '0;
            r_imm  <= '0;
        end else if (w_accept) begin
            r_snap <= flag_we ? alu_status : r_flags;
            r_cond <= br_cond;
            r_pc4  <= br_pc4;
            r_imm  <= br_imm;
        end
    end

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (r_cond)
            3'b000: w_taken = r_snap[1];
            3'b001: w_taken = !r_snap[1];
            3'b010: w_taken = r_snap[2];
            3'b011: w_taken = (r_snap[2] == r_snap[0]);
            3'b100: w_taken = r_snap[0];
            3'b101: w_taken = !r_snap[0];
            3'b110: w_taken = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_offset = {{SEXT_W{r_imm[IMM_W-1]}}, r_imm, 2'b00};
    assign w_target = w_taken ? (r_pc4 + w_offset) : r_pc4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_taken   <= 1'b0;
            r_target  <= '0;
            r_link    <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else if (r_state == S_EVAL) begin
            r_valid   <= 1'b1;
            r_taken   <= w_taken;
            r_target  <= w_target;
            r_link    <= r_pc4;
            r_illegal <= w_illegal;
            if (w_taken && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
        end else if ((r_state == S_RESP) && res_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign br_ready    = (r_state == S_IDLE) && reset_n;
    assign res_valid   = r_valid;
    assign res_taken   = r_taken;
    assign res_target  = r_target;
    assign res_link    = r_link;
    assign res_illegal = r_illegal;
    assign flags       = r_flags;
    assign taken_cnt   = r_cnt;

endmodule

// File: tb/tb_status_branch_unit.sv
// Bench for status_branch_unit: transaction-level reference model compared every
// cycle, directed literal cases, then randomized traffic; a CNT_W=2 copy shares inputs.
module tb_status_branch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        flag_we = 1'b0;
    logic [2:0]  alu_status = '0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_cond = '0;
    logic [31:0] br_pc4 = '0;
    logic [15:0] br_imm = '0;
    logic        res_ready = 1'b0;

    logic        br_ready, res_valid, res_taken, res_illegal;
    logic [31:0] res_target, res_link;
    logic [2:0]  flags;
    logic [15:0] taken_cnt;

    logic        s_br_ready, s_res_valid, s_res_taken, s_res_illegal;
    logic [31:0] s_res_target, s_res_link;
    logic [2:0]  s_flags;
    logic [1:0]  s_taken_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    status_branch_unit #(.DATA_W(32), .IMM_W(16), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .flag_we(flag_we), .alu_status(alu_status),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_pc4(br_pc4),
        .br_imm(br_imm), .res_valid(res_valid), .res_ready(res_ready),
        .res_taken(res_taken), .res_target(res_target), .res_link(res_link),
        .res_illegal(res_illegal), .flags(flags), .taken_cnt(taken_cnt)
    );

    status_branch_unit #(.DATA_W(32), .IMM_W(16), .CNT_W(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .flag_we(flag_we), .alu_status(alu_status),
        .br_valid(br_valid), .br_ready(s_br_ready), .br_cond(br_cond), .br_pc4(br_pc4),
        .br_imm(br_imm), .res_valid(s_res_valid), .res_ready(res_ready),
        .res_taken(s_res_taken), .res_target(s_res_target), .res_link(s_res_link),
        .res_illegal(s_res_illegal), .flags(s_flags), .taken_cnt(s_taken_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding branch with an age since acceptance.
    logic [2:0]  m_flags = '0;
    bit          m_busy = 0;
    int          m_age = 0;
    bit          m_taken = 0, m_illegal = 0;
    logic [31:0] m_target = '0, m_link = '0;
    int          m_cnt = 0, m_cnt2 = 0;

    function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
        bit n, z, v;
        n = f[2]; z = f[1]; v = f[0];
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return n;
            3'd3: return n == v;
            3'd4: return v;
            3'd5: return !v;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge reset_n) begin
        m_flags = '0; m_busy = 0; m_age = 0; m_cnt = 0; m_cnt2 = 0;
    end

    always @(posedge clk) begin
        if (reset_n) begin
            if (!m_busy) begin
                if (br_valid) begin
                    logic [2:0] snap;
                    snap      = flag_we ? alu_status : m_flags;
                    m_busy    = 1;
                    m_age     = 0;
                    m_illegal = (br_cond == 3'b111);
                    m_taken   = cond_true(br_cond, snap);
                    m_link    = br_pc4;
                    m_target  = m_taken ? br_pc4 + 32'($signed(br_imm)) * 32'd4 : br_pc4;
                end
            end else if (m_age == 0) begin
                m_age = 1;
                if (m_taken) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end else if (res_ready) begin
                m_busy = 0;
            end
            if (flag_we) m_flags = alu_status;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_br_ready", 64'(br_ready), 64'(0));
            chk("rst_res_valid", 64'(res_valid), 64'(0));
            chk("rst_res_taken", 64'(res_taken), 64'(0));
            chk("rst_res_target", 64'(res_target), 64'(0));
            chk("rst_res_link", 64'(res_link), 64'(0));
            chk("rst_res_illegal", 64'(res_illegal), 64'(0));
            chk("rst_flags", 64'(flags), 64'(0));
            chk("rst_taken_cnt", 64'(taken_cnt), 64'(0));
        end else begin
            chk("br_ready", 64'(br_ready), 64'(!m_busy));
            chk("res_valid", 64'(res_valid), 64'(m_busy && m_age == 1));
            chk("flags", 64'(flags), 64'(m_flags));
            chk("taken_cnt", 64'(taken_cnt), 64'(m_cnt));
            chk("sat_taken_cnt", 64'(s_taken_cnt), 64'(m_cnt2));
            if (m_busy && m_age == 1) begin
                chk("res_taken", 64'(res_taken), 64'(m_taken));
                chk("res_target", 64'(res_target), 64'(m_target));
                chk("res_link", 64'(res_link), 64'(m_link));
                chk("res_illegal", 64'(res_illegal), 64'(m_illegal));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [2:0] st);
        flag_we = 1'b1; alu_status = st;
        step();
        flag_we = 1'b0;
    endtask

    // Issues a request from IDLE and returns once the result is in RESP.
    task automatic branch(input logic [2:0] c, input logic [31:0] pc, input logic [15:0] im,
                          input logic fwe, input logic [2:0] st);
        br_valid = 1'b1; br_cond = c; br_pc4 = pc; br_imm = im;
        flag_we = fwe; alu_status = st;
        step();
        br_valid = 1'b0; flag_we = 1'b0;
        step();
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();

        set_flags(3'b010);
        branch(3'b000, 32'h100, 16'd4, 1'b0, 3'b000);
        chk("t1_valid", 64'(res_valid), 64'(1));
        chk("t1_taken", 64'(res_taken), 64'(1));
        chk("t1_target", 64'(res_target), 64'h110);
        chk("t1_cnt", 64'(taken_cnt), 64'(1));
        release_res();

        set_flags(3'b000);
        branch(3'b000, 32'h200, 16'd3, 1'b1, 3'b010);
        chk("bypass_taken", 64'(res_taken), 64'(1));
        flag_we = 1'b1; alu_status = 3'b000;
        step();
        flag_we = 1'b0;
        chk("resp_flag_we_taken", 64'(res_taken), 64'(1));
        release_res();

        set_flags(3'b101);
        branch(3'b011, 32'h300, 16'd5, 1'b0, 3'b000);
        chk("bge_eq_taken", 64'(res_taken), 64'(1));
        chk("bge_eq_target", 64'(res_target), 64'h314);
        release_res();
        set_flags(3'b100);
        branch(3'b011, 32'h300, 16'd5, 1'b0, 3'b000);
        chk("bge_ne_taken", 64'(res_taken), 64'(0));
        chk("bge_ne_target", 64'(res_target), 64'h300);
        release_res();

        branch(3'b110, 32'h4, 16'hFFFE, 1'b0, 3'b000);
        chk("bal_wrap_target", 64'(res_target), 64'hFFFF_FFFC);
        chk("bal_link", 64'(res_link), 64'h4);
        release_res();

        branch(3'b111, 32'h500, 16'd8, 1'b0, 3'b000);
        for (int i = 0; i < 5; i++) begin
            chk("ill_illegal", 64'(res_illegal), 64'(1));
            chk("ill_taken", 64'(res_taken), 64'(0));
            chk("ill_target", 64'(res_target), 64'h500);
            chk("ill_br_ready", 64'(br_ready), 64'(0));
            step();
        end
        reset_n = 1'b0;
        #1;
        chk("rst_in_resp_valid", 64'(res_valid), 64'(0));
        step();
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            branch(3'b110, 32'h1000, 16'd1, 1'b0, 3'b000);
            release_res();
        end
        chk("sat_cnt", 64'(s_taken_cnt), 64'(3));
        chk("full_cnt", 64'(taken_cnt), 64'(4));

        for (int i = 0; i < 800; i++) begin
            flag_we    = 1'($urandom_range(0, 3) == 0);
            alu_status = 3'($urandom);
            br_valid   = 1'($urandom);
            br_cond    = 3'($urandom);
            br_pc4     = $urandom;
            br_imm     = 16'($urandom);
            res_ready  = 1'($urandom_range(0, 2) != 0);
            step();
        end
        br_valid = 1'b0; flag_we = 1'b0; res_ready = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
